uart_tx_serializer: RTL and testbench

- UART transmitter: the return path from the CPU to the host PC, at the opposite end of the RX link that loads instructions.
- Accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serializes each one as an 8N1 frame (optionally more stop bits) on o_tx.
- Sits beside the instruction receiver in TOP_CPU; it is fed by the result-report logic (ALU result low/high, PC, opcode bytes).

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_tx_fifo.sv | 42 ++++
 rtl/uart_tx_serializer.sv | 94 +++++++++
 tb/tb_uart_tx_serializer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and constants shared by the UART transmitter and receiver
package uart_pkg;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular-buffer synchronous FIFO buffering bytes ahead of the serializer
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = UART_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wr_data,
  output logic [W-1:0]                 rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  // a full FIFO refuses a push even when a pop frees a slot on the same edge
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: buffered UART transmitter sending 8N1 frames (1 or 2 stop bits)
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [UART_DATA_W-1:0]            i_tx_data,
  input  logic                              i_tx_valid,
  output logic                              o_tx_ready,
  output logic                              o_tx,
  output logic                              o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count
);
  localparam int BAUD_W = $clog2(STOP_BITS*CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_W);
  localparam logic [BAUD_W-1:0] BIT_END = BAUD_W'(CLKS_PER_BIT-1);
  localparam logic [BAUD_W-1:0] STOP_END = BAUD_W'(STOP_BITS*CLKS_PER_BIT-1);
  uart_state_e state, state_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [UART_DATA_W-1:0] shift, shift_n, fifo_data;
  logic tx_n, pop, full, empty;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(UART_DATA_W)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .push(i_tx_valid),
    .pop(pop),
    .wr_data(i_tx_data),
    .rd_data(fifo_data),
    .full(full),
    .empty(empty),
    .count(o_fifo_count)
  );
  assign o_tx_ready = !full;
  assign o_busy = state != IDLE || !empty;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
      o_tx <= 1'b1;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      o_tx <= tx_n;
    end
  end
  // o_tx is registered, so each branch computes the line level for the next cycle
  always_comb begin
    state_n = state;
    baud_n = baud + 1'b1;
    bit_n = bit_cnt;
    shift_n = shift;
    tx_n = o_tx;
    pop = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        tx_n = empty;
        pop = !empty;
        shift_n = empty ? shift : fifo_data;
        state_n = empty ? IDLE : START;
      end
      START: if (baud == BIT_END) begin
        baud_n = '0;
        bit_n = '0;
        tx_n = shift[0];
        state_n = DATA;
      end
      DATA: if (baud == BIT_END) begin
        baud_n = '0;
        if (bit_cnt == BW'(UART_DATA_W-1)) begin
          tx_n = 1'b1;
          state_n = STOP;
        end else begin
          shift_n = shift >> 1;
          tx_n = shift[1];
          bit_n = bit_cnt + 1'b1;
        end
      end
      STOP: if (baud == STOP_END) begin
        baud_n = '0;
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: frame-position reference model, line decoder and vector table for the UART TX
module tb_uart_tx_serializer;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  localparam int FRAME1 = 10 * CPB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] data = '0, data2 = '0;
  logic valid = 1'b0, valid2 = 1'b0;
  logic ready, tx, busy, ready2, tx2, busy2;
  logic [2:0] count, count2;
  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] q[$];
  logic [7:0] m_byte = '0;
  int m_pos = 0;
  bit m_idle = 1'b1;
  int rx_cnt = -1;
  logic prev_tx = 1'b1;
  logic [7:0] rx_sh = '0;
  logic [7:0] rxq[$];
  typedef struct {
    logic [7:0] data;
    logic [10:0] frame;
  } vec_t;
  vec_t vecs[5];
  logic [7:0] b2b[6];

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_tx_data(data), .i_tx_valid(valid),
    .o_tx_ready(ready), .o_tx(tx), .o_busy(busy), .o_fifo_count(count)
  );
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(data2), .i_tx_valid(valid2),
    .o_tx_ready(ready2), .o_tx(tx2), .o_busy(busy2), .o_fifo_count(count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // one clock: advance the model by frame position, then compare dut against it and decode its line
  task automatic step();
    bit push_ok, exp_tx;
    int idx;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      m_idle = 1'b1;
      m_pos = 0;
    end else begin
      push_ok = valid && q.size() < DEPTH;
      if (m_idle) begin
        if (q.size() > 0) begin
          m_byte = q.pop_front();
          m_idle = 1'b0;
          m_pos = 0;
        end
      end else begin
        m_pos++;
        if (m_pos == FRAME1) m_idle = 1'b1;
      end
      if (push_ok) q.push_back(data);
    end
    #1;
    if (m_idle) exp_tx = 1'b1;
    else if (m_pos < CPB) exp_tx = 1'b0;
    else if (m_pos < 9 * CPB) exp_tx = m_byte[m_pos / CPB - 1];
    else exp_tx = 1'b1;
    chk("tx", tx, exp_tx);
    chk("ready", ready, q.size() < DEPTH);
    chk("busy", busy, !m_idle || q.size() > 0);
    chk("count", count, q.size());
    if (rst) rx_cnt = -1;
    else if (rx_cnt < 0) begin
      if (prev_tx === 1'b1 && tx === 1'b0) rx_cnt = 0;
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        idx = rx_cnt / CPB;
        if (idx >= 1 && idx <= 8) rx_sh[idx-1] = tx;
        if (idx == 9) begin
          if (tx === 1'b1) rxq.push_back(rx_sh);
          rx_cnt = -1;
        end
      end
    end
    prev_tx = tx;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 600 && (busy || rx_cnt >= 0); i++) step();
    chk(name, busy, 0);
  endtask

  task automatic push1(input logic [7:0] b);
    bit acc = 1'b0;
    data = b;
    valid = 1'b1;
    for (int g = 0; g < 400 && !acc; g++) begin
      acc = q.size() < DEPTH;
      step();
    end
    valid = 1'b0;
    chk("push_accept", acc, 1);
  endtask

  initial begin
    int t0;
    bit saw_low, acc;
    logic [10:0] cap;
    vecs[0] = '{8'h41, 11'h682};
    vecs[1] = '{8'h55, 11'h6AA};
    vecs[2] = '{8'hF0, 11'h7E0};
    vecs[3] = '{8'h12, 11'h624};
    vecs[4] = '{8'hA5, 11'h74A};
    b2b = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
    repeat (3) step();
    rst = 1'b0;
    repeat (100) step();

    rxq.delete();
    push1(8'h41);
    t0 = cyc;
    step();
    chk("single_fall", tx, 0);
    drain("single_drain");
    chk("single_len", cyc - t0, FRAME1 + 1);
    chk("single_rx_n", rxq.size(), 1);
    if (rxq.size() > 0) chk("single_rx", rxq[0], 8'h41);

    rxq.delete();
    saw_low = 1'b0;
    for (int k = 0; k < 6; k++) begin
      data = b2b[k];
      valid = 1'b1;
      acc = 1'b0;
      for (int g = 0; g < 400 && !acc; g++) begin
        if (k == 5 && !ready && count == 3'd4) saw_low = 1'b1;
        acc = q.size() < DEPTH;
        step();
      end
      chk("b2b_accept", acc, 1);
    end
    valid = 1'b0;
    chk("b2b_held_off", saw_low, 1);
    drain("b2b_drain");
    chk("b2b_rx_n", rxq.size(), 6);
    for (int k = 0; k < 6 && k < rxq.size(); k++) chk("b2b_rx", rxq[k], b2b[k]);

    rxq.delete();
    push1(8'hF0);
    repeat (18) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_tx", tx, 1);
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    push1(8'h12);
    drain("midrst_drain");
    chk("midrst_rx_n", rxq.size(), 1);
    if (rxq.size() > 0) chk("midrst_rx", rxq[0], 8'h12);

    foreach (vecs[v]) begin
      data2 = vecs[v].data;
      valid2 = 1'b1;
      step();
      valid2 = 1'b0;
      t0 = cyc;
      step();
      chk("s2_fall", tx2, 0);
      repeat (2) step();
      cap[0] = tx2;
      for (int i = 1; i < 11; i++) begin
        repeat (CPB) step();
        cap[i] = tx2;
      end
      chk("s2_frame", cap, vecs[v].frame);
      for (int i = 0; i < 100 && busy2; i++) step();
      chk("s2_len", cyc - t0, 11 * CPB + 1);
    end

    for (int c = 0; c < 3000; c++) begin
      if (!valid || acc) begin
        valid = $urandom_range(0, 7) < (((c / 500) % 2 == 1) ? 6 : 1);
        data = 8'($urandom);
      end
      rst = $urandom_range(0, 799) == 0;
      acc = valid && !rst && q.size() < DEPTH;
      step();
      rst = 1'b0;
    end
    valid = 1'b0;
    drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
